// File: rtl/mig_port_arbiter.sv
// mig_port_arbiter
// Shares the single DDR3 MIG user interface between NUM_WR capture writers and
// one sequential playback read stream. Each writer owns a fixed DRAM region of
// REGION_WORDS 128-bit words. Writers are served in round-robin bursts. Read
// bursts are interleaved with them, and a credit counter bounds the number of
// reads that are still in flight.
// Optional build macro: MIG_ARB_STATS_EN adds the saturating 32-bit counters
// stat_wr_beats, stat_rd_cmds and stat_stall.
module mig_port_arbiter #(
    parameter int NUM_WR          = 4,
    parameter int REGION_WORDS    = 23436,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         init_calib_complete,
    output logic [26:0]                  app_addr,
    output logic [2:0]                   app_cmd,
    output logic                         app_en,
    output logic [127:0]                 app_wdf_data,
    output logic                         app_wdf_wren,
    output logic                         app_wdf_end,
    input  logic                         app_rdy,
    input  logic                         app_wdf_rdy,
    input  logic                         app_rd_data_valid,
    input  logic [NUM_WR*128-1:0]        wr_data,
    input  logic [NUM_WR-1:0]            wr_valid,
    input  logic [NUM_WR-1:0]            wr_tlast,
    output logic [NUM_WR-1:0]            wr_ready,
    input  logic                         rd_en,
    input  logic [$clog2(NUM_WR)-1:0]    rd_sel,
    input  logic                         rd_af,
    output logic                         rd_tlast
`ifdef MIG_ARB_STATS_EN
    ,
    output logic [31:0]                  stat_wr_beats,
    output logic [31:0]                  stat_rd_cmds,
    output logic [31:0]                  stat_stall
`endif
);

    localparam int SEL_W = $clog2(NUM_WR);
    localparam int OFF_W = $clog2(REGION_WORDS);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int CRD_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        S_WAIT_INIT,
        S_ARB,
        S_WR,
        S_RD
    } state_t;

    state_t             state_reg;
    logic [SEL_W-1:0]   gnt_reg;
    logic [SEL_W-1:0]   rr_reg;
    logic               rd_pri_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CRD_W-1:0]   credit_reg;
    logic [SEL_W-1:0]   rsel_reg;
    logic [OFF_W-1:0]   roff_req_reg;
    logic [OFF_W-1:0]   roff_resp_reg;
    logic [OFF_W-1:0]   woff_reg [NUM_WR];

    logic               rd_credit_ok;
    logic               rd_eligible;
    logic               wr_any;
    logic               wr_cur_valid;
    logic               wr_cur_tlast;
    logic               beat;
    logic               issue;
    logic               resp_take;
    logic [SEL_W-1:0]   rr_pick;
    logic [SEL_W:0]     cand;
    logic               pick_hit;
    logic [SEL_W-1:0]   gnt_inc;
    logic [26:0]        wr_word;
    logic [26:0]        rd_word;

    assign rd_credit_ok = credit_reg < CRD_W'(MAX_OUTSTANDING);
    assign rd_eligible  = rd_en && rd_credit_ok && !rd_af;
    assign wr_any       = |wr_valid;
    assign wr_cur_valid = wr_valid[gnt_reg];
    assign wr_cur_tlast = wr_tlast[gnt_reg];
    assign beat         = (state_reg == S_WR) && wr_cur_valid && app_rdy && app_wdf_rdy;
    assign issue        = (state_reg == S_RD) && rd_eligible && app_rdy;
    // A response with no credit outstanding is not ours to count against credit.
    assign resp_take    = app_rd_data_valid && (credit_reg != '0);
    assign gnt_inc      = (gnt_reg == SEL_W'(NUM_WR - 1)) ? '0 : gnt_reg + SEL_W'(1);

    assign wr_word = 27'(gnt_reg) * 27'(REGION_WORDS) + 27'(woff_reg[gnt_reg]);
    assign rd_word = 27'(rsel_reg) * 27'(REGION_WORDS) + 27'(roff_req_reg);

    assign rd_tlast = app_rd_data_valid && (roff_resp_reg == OFF_W'(REGION_WORDS - 1));

    // First valid writer searching upward from the round-robin pointer, with wrap.
    always_comb begin
        rr_pick  = rr_reg;
        pick_hit = 1'b0;
        cand     = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            cand = {1'b0, rr_reg} + (SEL_W+1)'(k);
            if (cand >= (SEL_W+1)'(NUM_WR)) begin
                cand = cand - (SEL_W+1)'(NUM_WR);
            end
            if (!pick_hit && wr_valid[cand[SEL_W-1:0]]) begin
                rr_pick  = cand[SEL_W-1:0];
                pick_hit = 1'b1;
            end
        end
    end

    // MIG command and write-data outputs follow the current grant without a register stage.
    always_comb begin
        app_en       = 1'b0;
        app_cmd      = 3'b000;
        app_addr     = '0;
        app_wdf_data = '0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        case (state_reg)
            S_WR: begin
                app_en       = beat;
                app_cmd      = 3'b000;
                app_addr     = {wr_word[23:0], 3'b000};
                app_wdf_data = wr_data[int'(gnt_reg)*128 +: 128];
                app_wdf_wren = beat;
                app_wdf_end  = beat;
            end
            S_RD: begin
                app_en   = issue;
                app_cmd  = 3'b001;
                app_addr = {rd_word[23:0], 3'b000};
            end
            default: begin
            end
        endcase
    end

    // Only the granted writer sees ready, and only on a beat that actually transfers.
    generate
        for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_ready
            assign wr_ready[gi] = beat && (gnt_reg == SEL_W'(gi));
        end
    endgenerate

    // Scheduler: calibration wait, one-cycle arbitration, then a write or read burst.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg  <= S_WAIT_INIT;
            gnt_reg    <= '0;
            rr_reg     <= '0;
            rd_pri_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            case (state_reg)
                S_WAIT_INIT: begin
                    if (init_calib_complete) begin
                        state_reg <= S_ARB;
                    end
                end
                S_ARB: begin
                    cnt_reg <= '0;
                    if (rd_pri_reg && rd_eligible) begin
                        state_reg <= S_RD;
                    end else if (wr_any) begin
                        gnt_reg   <= rr_pick;
                        state_reg <= S_WR;
                    end else if (rd_eligible) begin
                        state_reg <= S_RD;
                    end
                end
                S_WR: begin
                    if (beat) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (wr_cur_tlast || (cnt_reg == CNT_W'(MAX_BURST - 1))) begin
                            state_reg  <= S_ARB;
                            rr_reg     <= gnt_inc;
                            rd_pri_reg <= 1'b1;
                        end
                    end else if (!wr_cur_valid) begin
                        state_reg  <= S_ARB;
                        rr_reg     <= gnt_inc;
                        rd_pri_reg <= 1'b1;
                    end
                end
                S_RD: begin
                    if (issue) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (cnt_reg == CNT_W'(MAX_BURST - 1)) begin
                            state_reg  <= S_ARB;
                            rd_pri_reg <= 1'b0;
                        end
                    end else if (!rd_eligible) begin
                        // app_rdy low on its own keeps the read burst alive.
                        state_reg  <= S_ARB;
                        rd_pri_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_WAIT_INIT;
                end
            endcase
        end
    end

    // Per-region write offsets; a tlast beat restarts the region at word 0.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_WR; i++) begin
                woff_reg[i] <= '0;
            end
        end else if (beat) begin
            if (wr_cur_tlast || (woff_reg[gnt_reg] == OFF_W'(REGION_WORDS - 1))) begin
                woff_reg[gnt_reg] <= '0;
            end else begin
                woff_reg[gnt_reg] <= woff_reg[gnt_reg] + OFF_W'(1);
            end
        end
    end

    // Read credit, request/response offsets and region latch (only while reads are idle and drained).
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            credit_reg    <= '0;
            rsel_reg      <= '0;
            roff_req_reg  <= '0;
            roff_resp_reg <= '0;
        end else begin
            if (issue && !resp_take) begin
                credit_reg <= credit_reg + CRD_W'(1);
            end else if (!issue && resp_take) begin
                credit_reg <= credit_reg - CRD_W'(1);
            end
            if (!rd_en && (credit_reg == '0)) begin
                rsel_reg      <= rd_sel;
                roff_req_reg  <= '0;
                roff_resp_reg <= '0;
            end else begin
                if (issue) begin
                    roff_req_reg <= (roff_req_reg == OFF_W'(REGION_WORDS - 1)) ? '0
                                  : roff_req_reg + OFF_W'(1);
                end
                if (app_rd_data_valid) begin
                    roff_resp_reg <= (roff_resp_reg == OFF_W'(REGION_WORDS - 1)) ? '0
                                   : roff_resp_reg + OFF_W'(1);
                end
            end
        end
    end

`ifdef MIG_ARB_STATS_EN
    logic stall_now;
    assign stall_now = ((state_reg == S_WR) && wr_cur_valid && !(app_rdy && app_wdf_rdy))
                    || ((state_reg == S_RD) && rd_eligible && !app_rdy);

    // Saturating activity counters for bring-up and bandwidth profiling.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stat_wr_beats <= '0;
            stat_rd_cmds  <= '0;
            stat_stall    <= '0;
        end else begin
            if (beat && (stat_wr_beats != '1)) begin
                stat_wr_beats <= stat_wr_beats + 32'd1;
            end
            if (issue && (stat_rd_cmds != '1)) begin
                stat_rd_cmds <= stat_rd_cmds + 32'd1;
            end
            if (stall_now && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mig_port_arbiter.sv
// Directed bench for mig_port_arbiter: calibration gating, round robin,
// tlast handling, read credit limit, region wrap and interleave with reset.
module tb_mig_port_arbiter;

    localparam int NUM_WR = 4;
    localparam int RW     = 23436;

    logic                  clk_in = 1'b0;
    logic                  rst_in;
    logic                  init_calib_complete;
    logic [26:0]           app_addr;
    logic [2:0]            app_cmd;
    logic                  app_en;
    logic [127:0]          app_wdf_data;
    logic                  app_wdf_wren;
    logic                  app_wdf_end;
    logic                  app_rdy;
    logic                  app_wdf_rdy;
    logic                  app_rd_data_valid;
    logic [NUM_WR*128-1:0] wr_data;
    logic [NUM_WR-1:0]     wr_valid;
    logic [NUM_WR-1:0]     wr_tlast;
    logic [NUM_WR-1:0]     wr_ready;
    logic                  rd_en;
    logic [1:0]            rd_sel;
    logic                  rd_af;
    logic                  rd_tlast;
`ifdef MIG_ARB_STATS_EN
    logic [31:0]           stat_wr_beats;
    logic [31:0]           stat_rd_cmds;
    logic [31:0]           stat_stall;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    mig_port_arbiter #(
        .NUM_WR(NUM_WR), .REGION_WORDS(RW), .MAX_BURST(16), .MAX_OUTSTANDING(8)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .init_calib_complete(init_calib_complete),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data_valid(app_rd_data_valid),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_tlast(wr_tlast), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_af(rd_af), .rd_tlast(rd_tlast)
`ifdef MIG_ARB_STATS_EN
        , .stat_wr_beats(stat_wr_beats), .stat_rd_cmds(stat_rd_cmds), .stat_stall(stat_stall)
`endif
    );

    // Hold reset a few cycles with all requesters idle, then release on a falling edge.
    task automatic apply_reset(input logic calib);
        @(negedge clk_in);
        rst_in = 1'b0;
        init_calib_complete = 1'b0;
        wr_valid = '0; wr_tlast = '0; rd_en = 1'b0; rd_af = 1'b0;
        app_rd_data_valid = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        init_calib_complete = calib;
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        rst_in = 1'b0; wr_valid = 4'b1111; rd_en = 1'b1; app_rd_data_valid = 1'b1;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; init_calib_complete = 1'b1;
        repeat (2) @(negedge clk_in);
        #1;
        $display("[reset] en=%0b wren=%0b end=%0b ready=%b tlast=%0b addr=%0d cmd=%0d",
                 app_en, app_wdf_wren, app_wdf_end, wr_ready, rd_tlast, app_addr, app_cmd);
        checks++;
        if ({app_en, app_wdf_wren, app_wdf_end, wr_ready, rd_tlast} !== 8'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b expected=00000000",
                     {app_en, app_wdf_wren, app_wdf_end, wr_ready, rd_tlast});
        end
        checks++;
        if (app_addr !== 27'd0 || app_cmd !== 3'd0) begin
            failures++;
            $display("FAIL reset_addr_cmd got addr=%0d cmd=%0d expected 0 0", app_addr, app_cmd);
        end
        checks++;
        if (app_wdf_data !== 128'd0) begin
            failures++;
            $display("FAIL reset_wdata got=%h expected=0", app_wdf_data);
        end
    endtask

    task automatic test_calib_gating();
        int bad;
        int lat;
        apply_reset(1'b0);
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_in);
            wr_valid = 4'b1111;
            #1;
            if (app_en !== 1'b0 || wr_ready !== 4'b0) bad++;
        end
        $display("[calib] 100 uncalibrated cycles, grant cycles seen=%0d", bad);
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL calib_gate got=%0d active cycles expected=0", bad);
        end
        lat = -1;
        for (int c = 0; c < 10 && lat < 0; c++) begin
            @(negedge clk_in);
            init_calib_complete = 1'b1;
            #1;
            if (app_en === 1'b1) lat = c;
        end
        $display("[calib] first beat latency=%0d addr=%0d ready=%b", lat, app_addr, wr_ready);
        checks++;
        if (lat != 2) begin
            failures++;
            $display("FAIL calib_latency got=%0d expected=2", lat);
        end
        checks++;
        if (wr_ready !== 4'b0001 || app_addr !== 27'd0 || app_cmd !== 3'd0) begin
            failures++;
            $display("FAIL calib_first_grant got ready=%b addr=%0d cmd=%0d expected 0001 0 0",
                     wr_ready, app_addr, app_cmd);
        end
        checks++;
        if (app_wdf_data !== {96'h0, 32'hD000_0000} || app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1) begin
            failures++;
            $display("FAIL calib_first_data got=%h wren=%0b end=%0b", app_wdf_data, app_wdf_wren, app_wdf_end);
        end
    endtask

    task automatic test_round_robin();
        int bw [80];
        int ba [80];
        int bc [80];
        logic [127:0] bd [80];
        int n;
        int order_bad;
        int w;
        apply_reset(1'b1);
        n = 0;
        order_bad = 0;
        for (int c = 0; c < 300 && n < 80; c++) begin
            @(negedge clk_in);
            wr_valid = 4'b1111;
            #1;
            if (app_en === 1'b1) begin
                w = -1;
                for (int i = 0; i < NUM_WR; i++) if (wr_ready[i]) w = i;
                if (!$onehot(wr_ready) || app_cmd !== 3'd0) order_bad++;
                bw[n] = w; ba[n] = int'(app_addr); bc[n] = c; bd[n] = app_wdf_data;
                n++;
            end
        end
        for (int b = 0; b < 5; b++)
            $display("[rr] burst %0d writer=%0d first_addr=%0d", b, bw[b*16], ba[b*16]);
        checks++;
        if (n != 80) begin
            failures++;
            $display("FAIL rr_beat_count got=%0d expected=80", n);
        end
        for (int k = 0; k < n; k++) if (bw[k] != (k / 16) % 4) order_bad++;
        checks++;
        if (order_bad != 0) begin
            failures++;
            $display("FAIL rr_order got=%0d bad beats expected=0", order_bad);
        end
        checks++;
        if (ba[16] != 187488 || ba[32] != 374976) begin
            failures++;
            $display("FAIL rr_region_addr got w1=%0d w2=%0d expected 187488 374976", ba[16], ba[32]);
        end
        checks++;
        if (ba[64] != 128 || ba[79] != 248) begin
            failures++;
            $display("FAIL rr_second_pass got=%0d,%0d expected=128,248", ba[64], ba[79]);
        end
        checks++;
        if (bc[16] - bc[15] != 2 || bc[15] - bc[0] != 15) begin
            failures++;
            $display("FAIL rr_burst_timing got span=%0d gap=%0d expected 15 2", bc[15] - bc[0], bc[16] - bc[15]);
        end
        checks++;
        if (bd[48] !== {96'h0, 32'hD000_0003}) begin
            failures++;
            $display("FAIL rr_wdata got=%h expected=%h", bd[48], {96'h0, 32'hD000_0003});
        end
    endtask

    task automatic test_tlast();
        int ba [7];
        int bc [7];
        int n;
        apply_reset(1'b1);
        n = 0;
        for (int c = 0; c < 60 && n < 7; c++) begin
            @(negedge clk_in);
            wr_valid = 4'b0010;
            wr_tlast = (n == 4) ? 4'b0010 : 4'b0000;
            #1;
            if (app_en === 1'b1) begin
                ba[n] = int'(app_addr); bc[n] = c;
                $display("[tlast] beat %0d addr=%0d tlast=%b ready=%b", n, ba[n], wr_tlast, wr_ready);
                n++;
            end
        end
        wr_tlast = '0;
        checks++;
        if (n != 7) begin
            failures++;
            $display("FAIL tlast_beats got=%0d expected=7", n);
        end else begin
            checks++;
            if (ba[0] != 187488 || ba[4] != 187520) begin
                failures++;
                $display("FAIL tlast_first_burst got=%0d,%0d expected=187488,187520", ba[0], ba[4]);
            end
            checks++;
            if (bc[4] - bc[0] != 4 || bc[5] - bc[4] != 2) begin
                failures++;
                $display("FAIL tlast_burst_end got span=%0d gap=%0d expected 4 2", bc[4] - bc[0], bc[5] - bc[4]);
            end
            checks++;
            if (ba[5] != 187488 || ba[6] != 187496) begin
                failures++;
                $display("FAIL tlast_restart got=%0d,%0d expected=187488,187496", ba[5], ba[6]);
            end
        end
    endtask

    task automatic test_credit_limit();
        int nrd;
        int nwr;
        int last;
        int tl;
        apply_reset(1'b1);
        rd_sel = 2'd0;
        @(negedge clk_in);
        nrd = 0; nwr = 0; last = -1; tl = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_in);
            rd_en = 1'b1;
            #1;
            if (app_en === 1'b1 && app_cmd === 3'd1) begin
                last = int'(app_addr);
                $display("[credit] read %0d addr=%0d", nrd, last);
                nrd++;
            end
            if (app_en === 1'b1 && app_cmd === 3'd0) nwr++;
        end
        checks++;
        if (nrd != 8 || nwr != 0) begin
            failures++;
            $display("FAIL credit_limit got reads=%0d writes=%0d expected 8 0", nrd, nwr);
        end
        checks++;
        if (last != 56) begin
            failures++;
            $display("FAIL credit_last_addr got=%0d expected=56", last);
        end
        nrd = 0; last = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_in);
            app_rd_data_valid = (c == 0);
            #1;
            if (rd_tlast === 1'b1) tl++;
            if (app_en === 1'b1 && app_cmd === 3'd1) begin
                last = int'(app_addr);
                $display("[credit] read after response addr=%0d", last);
                nrd++;
            end
        end
        app_rd_data_valid = 1'b0;
        checks++;
        if (nrd != 1 || last != 64) begin
            failures++;
            $display("FAIL credit_refill got reads=%0d addr=%0d expected 1 64", nrd, last);
        end
        checks++;
        if (tl != 0) begin
            failures++;
            $display("FAIL credit_tlast got=%0d pulses expected=0", tl);
        end
    endtask

    task automatic test_wrap_tlast();
        int pend, nis, nresp, tl_cnt, tl_at, addr_bad, addr_wrap, exp_addr, iss;
        apply_reset(1'b1);
        rd_sel = 2'd3;
        @(negedge clk_in);
        pend = 0; nis = 0; nresp = 0; tl_cnt = 0; tl_at = -1; addr_bad = 0; addr_wrap = -1;
        for (int c = 0; c < 40000 && !(nresp >= RW + 2 && nis >= RW + 2); c++) begin
            @(negedge clk_in);
            rd_en = 1'b1;
            app_rd_data_valid = (pend > 0);
            #1;
            if (app_rd_data_valid) nresp++;
            if (rd_tlast === 1'b1) begin
                tl_cnt++; tl_at = nresp;
            end
            iss = (app_en === 1'b1 && app_cmd === 3'd1) ? 1 : 0;
            if (iss == 1) begin
                exp_addr = (3 * RW + (nis % RW)) * 8;
                if (int'(app_addr) != exp_addr) addr_bad++;
                if (nis == RW) addr_wrap = int'(app_addr);
                nis++;
            end
            pend = pend + iss - (app_rd_data_valid ? 1 : 0);
        end
        app_rd_data_valid = 1'b0;
        rd_en = 1'b0;
        $display("[wrap] issued=%0d responses=%0d tlast_at=%0d wrap_addr=%0d", nis, nresp, tl_at, addr_wrap);
        checks++;
        if (nresp < RW + 2 || nis < RW + 2) begin
            failures++;
            $display("FAIL wrap_progress got issued=%0d responses=%0d expected >= %0d", nis, nresp, RW + 2);
        end
        checks++;
        if (tl_cnt != 1 || tl_at != RW) begin
            failures++;
            $display("FAIL wrap_tlast got pulses=%0d at=%0d expected 1 at %0d", tl_cnt, tl_at, RW);
        end
        checks++;
        if (addr_bad != 0) begin
            failures++;
            $display("FAIL wrap_addr_seq got=%0d bad addresses expected=0", addr_bad);
        end
        checks++;
        if (addr_wrap != 562464) begin
            failures++;
            $display("FAIL wrap_restart_addr got=%0d expected=562464", addr_wrap);
        end
    endtask

    task automatic test_interleave_reset();
        int kind [64];
        int n, pend, bad, iss, nwb, seen;
        apply_reset(1'b1);
        rd_sel = 2'd0;
        n = 0; pend = 0; bad = 0;
        for (int c = 0; c < 200 && n < 64; c++) begin
            @(negedge clk_in);
            wr_valid = 4'b0001; rd_en = 1'b1;
            app_rd_data_valid = (pend > 0);
            #1;
            iss = (app_en === 1'b1 && app_cmd === 3'd1) ? 1 : 0;
            if (app_en === 1'b1) begin
                kind[n] = int'(app_cmd);
                n++;
            end
            pend = pend + iss - (app_rd_data_valid ? 1 : 0);
        end
        for (int b = 0; b < 4; b++) $display("[interleave] burst %0d cmd=%0d", b, kind[b*16]);
        for (int k = 0; k < n; k++) if (kind[k] != (k / 16) % 2) bad++;
        checks++;
        if (n != 64 || bad != 0) begin
            failures++;
            $display("FAIL interleave_order got cmds=%0d bad=%0d expected 64 0", n, bad);
        end
        nwb = 0;
        for (int c = 0; c < 60 && nwb < 3; c++) begin
            @(negedge clk_in);
            app_rd_data_valid = (pend > 0);
            #1;
            iss = (app_en === 1'b1 && app_cmd === 3'd1) ? 1 : 0;
            if (app_en === 1'b1 && app_cmd === 3'd0) nwb++;
            if (nwb < 3) pend = pend + iss - (app_rd_data_valid ? 1 : 0);
        end
        checks++;
        if (nwb != 3) begin
            failures++;
            $display("FAIL interleave_wr_found got=%0d beats expected=3", nwb);
        end
        rst_in = 1'b0;
        app_rd_data_valid = 1'b0;
        init_calib_complete = 1'b0;
        #1;
        $display("[reset_mid] en=%0b ready=%b wren=%0b", app_en, wr_ready, app_wdf_wren);
        checks++;
        if (app_en !== 1'b0 || wr_ready !== 4'b0 || app_wdf_wren !== 1'b0) begin
            failures++;
            $display("FAIL midburst_reset got en=%0b ready=%b wren=%0b expected 0 0000 0",
                     app_en, wr_ready, app_wdf_wren);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_in);
            rd_en = 1'b0;
            #1;
            if (app_en !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL post_reset_wait got=%0d commands expected=0", bad);
        end
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk_in);
            init_calib_complete = 1'b1;
            #1;
            if (app_en === 1'b1) seen = 1;
        end
        $display("[reset_mid] after calibration addr=%0d ready=%b", app_addr, wr_ready);
        checks++;
        if (seen != 1 || app_addr !== 27'd0 || wr_ready !== 4'b0001) begin
            failures++;
            $display("FAIL post_reset_grant got seen=%0d addr=%0d ready=%b expected 1 0 0001",
                     seen, app_addr, wr_ready);
        end
    endtask

    initial begin
        rst_in = 1'b0;
        init_calib_complete = 1'b0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0;
        wr_valid = '0; wr_tlast = '0; rd_en = 1'b0; rd_sel = '0; rd_af = 1'b0;
        for (int i = 0; i < NUM_WR; i++) wr_data[i*128 +: 128] = {96'h0, 32'hD000_0000 + 32'(i)};
        test_reset();
        test_calib_gating();
        test_round_robin();
        test_tlast();
        test_credit_limit();
        test_wrap_tlast();
        test_interleave_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
